random_pulse_gen_mc: RTL and testbench

Synthesisable, multi-channel, cycle-based pseudo-random pulse generator for the fine-delay test and loopback path. Each of `g_num_channels` independent channels emits pulses of programmable width, spaced by a programmable minimum plus a masked LFSR offset. Three modes are supported: continuous random, fixed period and counted burst. The block drives trigger inputs in self-test and simulation benches, and can be instantiated in-chip for BIST.

---
 rtl/random_pulse_gen_mc.sv | 145 ++++++++++++++
 tb/tb_random_pulse_gen_mc.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/random_pulse_gen_mc.sv
// Multi-channel pseudo-random pulse generator: per-channel IDLE/HIGH/GAP/HOLD FSM, each with its own Galois LFSR.
// Registered outputs, pulse_o rises on the edge that samples enable in IDLE; no backpressure, config latched at each HIGH entry.
module random_pulse_gen_mc #(
    parameter int          g_num_channels = 4,
    parameter int          g_cnt_width    = 16,
    parameter logic [31:0] g_seed         = 32'hACE1_0001
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_n_i,
    input  logic [g_num_channels-1:0] enable_i,
    input  logic [1:0]                mode_i,
    input  logic [g_cnt_width-1:0]    width_i,
    input  logic [g_cnt_width-1:0]    min_space_i,
    input  logic [g_cnt_width-1:0]    range_mask_i,
    input  logic [g_cnt_width-1:0]    burst_len_i,
    output logic [g_num_channels-1:0] pulse_o,
    output logic [g_num_channels-1:0] busy_o,
    output logic [g_num_channels-1:0] done_o
);
    localparam int          W            = g_cnt_width;
    localparam logic [31:0] c_taps       = 32'h8020_0003;
    localparam logic [W-1:0] c_one       = W'(1);
    localparam logic [W-1:0] c_two       = W'(2);
    localparam logic [1:0]  c_mode_fixed = 2'b01;
    localparam logic [1:0]  c_mode_burst = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP, S_HOLD} state_t;

    logic [W-1:0] w_width_ld;
    logic [W-1:0] w_blen_ld;

    assign w_width_ld = (width_i == '0) ? c_one : width_i;
    assign w_blen_ld  = (burst_len_i == '0) ? '0 : burst_len_i - c_one;

    for (genvar n = 0; n < g_num_channels; n++) begin : g_ch
        localparam logic [31:0] c_seed_raw = g_seed ^ (32'(n) * 32'h9E37_79B9);
        localparam logic [31:0] c_seed     = (c_seed_raw == 32'd0) ? 32'd1 : c_seed_raw;

        state_t       r_state;
        logic [W-1:0] r_wcnt;
        logic [W-1:0] r_gcnt;
        logic [W-1:0] r_bcnt;
        logic [W-1:0] r_min_space;
        logic [W-1:0] r_mask;
        logic [1:0]   r_mode;
        logic [31:0]  r_lfsr;
        logic         r_pulse;
        logic         r_busy;
        logic         r_done;

        logic [W:0]   w_sum;
        logic [W-1:0] w_gap_sel;
        logic [W-1:0] w_gap;
        logic [31:0]  w_lfsr_nxt;
        logic         w_burst_end;

        // Extra spacing is summed one bit wider so an overflow saturates instead of wrapping short.
        assign w_sum       = {1'b0, r_min_space} + {1'b0, r_lfsr[W-1:0] & r_mask};
        assign w_gap_sel   = (r_mode == c_mode_fixed) ? r_min_space : (w_sum[W] ? '1 : w_sum[W-1:0]);
        assign w_gap       = (w_gap_sel == '0) ? c_one : w_gap_sel;
        assign w_lfsr_nxt  = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_taps : 32'd0);
        assign w_burst_end = (r_mode == c_mode_burst) && (r_bcnt == '0);

        always_ff @(posedge clk_sys_i) begin
            if (!rst_n_i) begin
                r_state     <= S_IDLE;
                r_wcnt      <= '0;
                r_gcnt      <= '0;
                r_bcnt      <= '0;
                r_min_space <= '0;
                r_mask      <= '0;
                r_mode      <= 2'b00;
                r_lfsr      <= c_seed;
                r_pulse     <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b0;
            end else begin
                r_done <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (enable_i[n]) begin
                            r_state     <= S_HIGH;
                            r_wcnt      <= w_width_ld;
                            r_mode      <= mode_i;
                            r_min_space <= min_space_i;
                            r_mask      <= range_mask_i;
                            r_bcnt      <= w_blen_ld;
                            r_pulse     <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                    S_HIGH: begin
                        if (r_wcnt == c_one) begin
                            r_state <= S_GAP;
                            r_gcnt  <= w_gap;
                            r_lfsr  <= w_lfsr_nxt;
                            r_pulse <= 1'b0;
                            r_done  <= w_burst_end && (w_gap == c_one);
                        end else begin
                            r_wcnt <= r_wcnt - c_one;
                        end
                    end
                    S_GAP: begin
                        if (r_gcnt == c_one) begin
                            if (w_burst_end) begin
                                r_state <= S_HOLD;
                            end else if (enable_i[n]) begin
                                r_state     <= S_HIGH;
                                r_wcnt      <= w_width_ld;
                                r_mode      <= mode_i;
                                r_min_space <= min_space_i;
                                r_mask      <= range_mask_i;
                                r_pulse     <= 1'b1;
                                if (r_mode == c_mode_burst) begin
                                    r_bcnt <= r_bcnt - c_one;
                                end
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_gcnt <= r_gcnt - c_one;
                            // done_o must land on the last GAP cycle, so it is armed one cycle early.
                            r_done <= w_burst_end && (r_gcnt == c_two);
                        end
                    end
                    S_HOLD: begin
                        if (!enable_i[n]) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end

        assign pulse_o[n] = r_pulse;
        assign busy_o[n]  = r_busy;
        assign done_o[n]  = r_done;
    end

endmodule

// File: tb/tb_random_pulse_gen_mc.sv
// Directed bench for random_pulse_gen_mc: waveform-level model compared every cycle, plus literal pins.
module tb_random_pulse_gen_mc;
    localparam int N = 4;
    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] en;
    logic [1:0]   mode;
    logic [W-1:0] width;
    logic [W-1:0] ms;
    logic [W-1:0] mask;
    logic [W-1:0] blen;
    logic [N-1:0] pulse;
    logic [N-1:0] busy;
    logic [N-1:0] done;

    int n_chk = 0;
    int n_fail = 0;

    random_pulse_gen_mc #(
        .g_num_channels(N),
        .g_cnt_width   (W),
        .g_seed        (32'hACE1_0001)
    ) dut (
        .clk_sys_i   (clk),
        .rst_n_i     (rst_n),
        .enable_i    (en),
        .mode_i      (mode),
        .width_i     (width),
        .min_space_i (ms),
        .range_mask_i(mask),
        .burst_len_i (blen),
        .pulse_o     (pulse),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each pulse is a waveform of w high cycles then g low cycles, indexed by position.
    int           m_ph[N];
    int           m_pos[N];
    int           m_w[N];
    int           m_g[N];
    int           m_rem[N];
    int           m_md[N];
    bit           m_last[N];
    logic [31:0]  m_lf[N];
    logic [N-1:0] e_pulse;
    logic [N-1:0] e_busy;
    logic [N-1:0] e_done;
    bit           m_valid = 1'b0;

    function automatic logic [31:0] seed_of(input int n);
        logic [31:0] s;
        s = 32'hACE1_0001 ^ (32'(n) * 32'h9E37_79B9);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'd0);
    endfunction

    function automatic int gap_of(input int md, input int ms_v, input int mk, input logic [31:0] l);
        int g;
        if (md == 1) begin
            g = ms_v;
        end else begin
            g = ms_v + (int'(l[15:0]) & mk);
            if (g > 65535) g = 65535;
        end
        if (g < 1) g = 1;
        return g;
    endfunction

    task automatic m_start(input int n);
        m_md[n]   = int'(mode);
        m_w[n]    = (width == 0) ? 1 : int'(width);
        m_g[n]    = gap_of(m_md[n], int'(ms), int'(mask), m_lf[n]);
        m_lf[n]   = lfsr_step(m_lf[n]);
        m_last[n] = (m_md[n] == 2) && (m_rem[n] == 0);
        m_pos[n]  = 0;
        m_ph[n]   = 1;
    endtask

    always @(posedge clk) begin
        for (int n = 0; n < N; n++) begin
            if (!rst_n) begin
                m_ph[n]  = 0;
                m_pos[n] = 0;
                m_lf[n]  = seed_of(n);
            end else if (m_ph[n] == 0) begin
                if (en[n]) begin
                    m_rem[n] = (blen == 0) ? 0 : int'(blen) - 1;
                    m_start(n);
                end
            end else if (m_ph[n] == 1) begin
                m_pos[n]++;
                if (m_pos[n] == m_w[n] + m_g[n]) begin
                    if (m_last[n]) begin
                        m_ph[n] = 2;
                    end else if (en[n]) begin
                        if (m_md[n] == 2) m_rem[n]--;
                        m_start(n);
                    end else begin
                        m_ph[n] = 0;
                    end
                end
            end else if (!en[n]) begin
                m_ph[n] = 0;
            end
            e_pulse[n] = (m_ph[n] == 1) && (m_pos[n] < m_w[n]);
            e_busy[n]  = (m_ph[n] != 0);
            e_done[n]  = (m_ph[n] == 1) && m_last[n] && (m_pos[n] == m_w[n] + m_g[n] - 1);
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_chk++;
            if (pulse !== e_pulse || busy !== e_busy || done !== e_done) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t pulse=%b want %b busy=%b want %b done=%b want %b",
                         $time, pulse, e_pulse, busy, e_busy, done, e_done);
            end
        end
    end

    // Monitor of DUT waveforms: run lengths, rise-to-rise period, random-gap statistics.
    int          cyc;
    bit          prev[N];
    bit          fell[N];
    bit          had_rise[N];
    int          hi_r[N];
    int          lo_r[N];
    int          last_hi[N];
    int          last_lo[N];
    int          rises[N];
    int          dones[N];
    int          last_rise[N];
    int          sig[N];
    int          gidx[N];
    int          gfirst[N][2];
    int          bad_range;
    int          per_bad;
    int          exp_period;
    logic [15:0] seen0;
    bit          per_chk;
    bit          rand_on;

    always @(negedge clk) begin
        cyc++;
        for (int n = 0; n < N; n++) begin
            if (!rst_n) begin
                prev[n]     = 1'b0;
                fell[n]     = 1'b0;
                had_rise[n] = 1'b0;
            end else begin
                if (pulse[n] && !prev[n]) begin
                    if (fell[n]) begin
                        last_lo[n] = lo_r[n];
                        if (rand_on) begin
                            if (lo_r[n] < 10 || lo_r[n] > 25) bad_range++;
                            else if (n == 0) seen0[lo_r[n] - 10] = 1'b1;
                            sig[n] = sig[n] * 31 + lo_r[n];
                            if (gidx[n] < 2) gfirst[n][gidx[n]] = lo_r[n];
                            gidx[n]++;
                        end
                    end
                    if (per_chk && had_rise[n] && (cyc - last_rise[n] != exp_period)) per_bad++;
                    last_rise[n] = cyc;
                    had_rise[n]  = 1'b1;
                    rises[n]++;
                    hi_r[n] = 0;
                end
                if (!pulse[n] && prev[n]) begin
                    last_hi[n] = hi_r[n];
                    lo_r[n]    = 0;
                    fell[n]    = 1'b1;
                end
                if (pulse[n]) hi_r[n]++;
                else lo_r[n]++;
                if (done[n]) dones[n]++;
                prev[n] = pulse[n];
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input logic [N-1:0] m, input int lim, input string nm);
        int k;
        k = 0;
        while ((busy & m) != 0 && k < lim) begin
            tick(1);
            k++;
        end
        check(nm, int'((busy & m) == 0), 1);
    endtask

    int r0[N];
    int d0[N];
    int ok;
    int hi;
    int lo;
    int k;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 4'hF; mode = 2'b01; width = 16'd3; ms = 16'd5; mask = 16'd0; blen = 16'd0;
        per_chk = 1'b0; rand_on = 1'b0; seen0 = 16'h0; exp_period = 0;

        // Reset with enable held high, then start one cycle after release.
        tick(3);
        @(negedge clk);
        check("reset pulse_o", int'(pulse), 0);
        check("reset busy_o", int'(busy), 0);
        check("reset done_o", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("start pulse_o", int'(pulse), 15);
        check("start busy_o", int'(busy), 15);

        // Fixed mode 3 high / 5 low.
        tick(1);
        r0[0] = rises[0]; exp_period = 8; per_chk = 1'b1;
        tick(800);
        per_chk = 1'b0;
        check("fixed rises", rises[0] - r0[0], 100);
        check("fixed period errors", per_bad, 0);
        check("fixed high width", last_hi[0], 3);
        check("fixed low width", last_lo[0], 5);

        // Width 0 / space 0 gives a 1/1 toggle.
        width = 16'd0; ms = 16'd0;
        tick(20);
        r0[0] = rises[0]; exp_period = 2; per_chk = 1'b1;
        tick(200);
        per_chk = 1'b0;
        check("toggle rises", rises[0] - r0[0], 100);
        check("toggle period errors", per_bad, 0);
        check("toggle high width", last_hi[0], 1);
        check("toggle low width", last_lo[0], 1);

        // Random mode from fresh seeds.
        rst_n = 1'b0; mode = 2'b00; width = 16'd1; ms = 16'd10; mask = 16'h000F;
        for (int n = 0; n < N; n++) begin
            sig[n] = 0; gidx[n] = 0;
        end
        bad_range = 0; seen0 = 16'h0; rand_on = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(6000);
        rand_on = 1'b0;
        check("random gap out of range", bad_range, 0);
        check("random all 16 offsets", int'(seen0), 65535);
        check("random ch0 gap0", gfirst[0][0], 11);
        check("random ch0 gap1", gfirst[0][1], 13);
        check("random ch1 gap0", gfirst[1][0], 18);
        check("random ch1 gap1", gfirst[1][1], 22);
        ok = 0;
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++)
                if (sig[a] == sig[b]) ok++;
        check("random equal channel sequences", ok, 0);

        // Burst of 4, hold, re-arm.
        en = 4'h0;
        wait_idle(4'hF, 60, "random stop idle");
        mode = 2'b10; blen = 16'd4; width = 16'd2; ms = 16'd3; mask = 16'd0;
        for (int n = 0; n < N; n++) begin
            r0[n] = rises[n]; d0[n] = dones[n];
        end
        en = 4'hF;
        tick(40);
        ok = 0;
        for (int n = 0; n < N; n++) if (rises[n] - r0[n] == 4 && dones[n] - d0[n] == 1) ok++;
        check("burst1 channels with 4 pulses and 1 done", ok, 4);
        check("burst hold busy_o", int'(busy), 15);
        check("burst hold pulse_o", int'(pulse), 0);
        en = 4'h0;
        tick(1);
        check("burst release busy_o", int'(busy), 0);
        en = 4'hF;
        tick(40);
        ok = 0;
        for (int n = 0; n < N; n++) if (rises[n] - r0[n] == 8 && dones[n] - d0[n] == 2) ok++;
        check("burst2 channels with 8 pulses and 2 dones", ok, 4);

        // Enable dropped during HIGH cycle 2 of a 10-wide pulse.
        en = 4'h0;
        tick(1);
        mode = 2'b01; width = 16'd10; ms = 16'd4;
        en = 4'b0001;
        tick(1);
        tick(1);
        en = 4'h0;
        hi = 1; lo = 0; k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (!busy[0]) break;
            if (pulse[0]) hi++;
            else lo++;
            k++;
        end
        check("drop high cycles", hi, 10);
        check("drop gap cycles", lo, 4);
        check("drop idle reached", int'(busy[0]), 0);

        // Reset during HIGH cycle 5.
        en = 4'b0001;
        @(posedge clk);
        #1;
        tick(4);
        check("pre-reset pulse", int'(pulse[0]), 1);
        rst_n = 1'b0;
        tick(1);
        check("reset mid-pulse pulse_o", int'(pulse[0]), 0);
        check("reset mid-pulse busy_o", int'(busy[0]), 0);
        en = 4'h0;
        rst_n = 1'b1;

        // Saturated gap, then width change mid-gap.
        mode = 2'b00; width = 16'd4; ms = 16'hFFFF; mask = 16'h000F;
        en = 4'b0001;
        tick(10);
        check("sat first width", last_hi[0], 4);
        width = 16'd7; ms = 16'd2; mask = 16'd0;
        r0[0] = rises[0]; k = 0;
        while (rises[0] == r0[0] && k < 70000) begin
            tick(1);
            k++;
        end
        check("sat next pulse in time", int'(rises[0] != r0[0]), 1);
        check("sat gap length", last_lo[0], 65535);
        en = 4'h0;
        tick(10);
        check("changed width", last_hi[0], 7);
        wait_idle(4'b0001, 20, "final idle");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
